comparator_rr_scheduler: RTL and testbench

//  Shares one Comparator_4_Bit instance between NUM_REQ requesters.
//  A round-robin arbiter grants one request per transaction; the scheduler registers the operands,

---
 rtl/comparator_pkg.sv | 15 +
 rtl/Comparator_4_Bit.sv | 16 +
 rtl/round_robin_arbiter.sv | 36 +++
 rtl/comparator_rr_scheduler.sv | 132 +++++++++++++
 tb/tb_comparator_rr_scheduler.sv | 221 ++++++++++++++++++++++
 5 files changed

// File: rtl/comparator_pkg.sv
// Shared types for the comparator scheduler:
// FSM states and one-hot result codes.
package comparator_pkg;

  typedef enum logic [1:0] {
    IDLE,
    COMPARE,
    RESPOND
  } cmp_sched_state_t;

  localparam logic [2:0] RES_GT = 3'b100;
  localparam logic [2:0] RES_EQ = 3'b010;
  localparam logic [2:0] RES_LT = 3'b001;

endpackage

// File: rtl/Comparator_4_Bit.sv
// 4-bit magnitude comparator with enable.
// Outputs float when disabled.
module Comparator_4_Bit (
  input  logic [3:0] A_In,
  input  logic [3:0] B_In,
  input  logic       Enable_In,
  output wire        A_gt_B_Out,
  output wire        A_eq_B_Out,
  output wire        A_lt_B_Out
);

  assign A_gt_B_Out = Enable_In ? (A_In > B_In) : 1'bz;
  assign A_eq_B_Out = Enable_In ? (A_In == B_In) : 1'bz;
  assign A_lt_B_Out = Enable_In ? (A_In < B_In) : 1'bz;

endmodule

// File: rtl/round_robin_arbiter.sv
// Combinational round-robin picker: first
// set request at or above ptr_i, with wrap.
module round_robin_arbiter #(
  parameter int NUM_REQ  = 4,
  parameter int ID_WIDTH = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic [NUM_REQ-1:0]  req_i,
  input  logic [ID_WIDTH-1:0] ptr_i,
  input  logic                enable_i,
  output logic [NUM_REQ-1:0]  grant_o,
  output logic [ID_WIDTH-1:0] idx_o,
  output logic                valid_o
);

  // scan requesters starting at the pointer, take the first hit
  always_comb begin
    int j;
    logic [ID_WIDTH-1:0] jj;
    j       = 0;
    jj      = '0;
    grant_o = '0;
    idx_o   = '0;
    valid_o = 1'b0;
    for (int k = 0; k < NUM_REQ; k++) begin
      j = int'(ptr_i) + k;
      if (j >= NUM_REQ) j -= NUM_REQ;
      jj = ID_WIDTH'(j);
      if (enable_i && !valid_o && req_i[jj]) begin
        grant_o[jj] = 1'b1;
        idx_o       = jj;
        valid_o     = 1'b1;
      end
    end
  end

endmodule

// File: rtl/comparator_rr_scheduler.sv
// Time-shares one 4-bit comparator among
// NUM_REQ requesters with round-robin grants.
module comparator_rr_scheduler #(
  parameter int NUM_REQ   = 4,
  parameter int ID_WIDTH  = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1,
  parameter int CNT_WIDTH = 8
) (
  input  logic                  Clk_In,
  input  logic                  Reset_n_In,
  input  logic [NUM_REQ-1:0]    Req_Valid_In,
  input  logic [4*NUM_REQ-1:0]  Req_Data_A_In,
  input  logic [4*NUM_REQ-1:0]  Req_Data_B_In,
  output logic [NUM_REQ-1:0]    Req_Ready_Out,
  output logic                  Rsp_Valid_Out,
  input  logic                  Rsp_Ready_In,
  output logic [ID_WIDTH-1:0]   Rsp_Id_Out,
  output logic [2:0]            Rsp_Result_Out,
  output logic                  Busy_Out,
  output logic [CNT_WIDTH-1:0]  Done_Count_Out
);

  import comparator_pkg::*;

  cmp_sched_state_t state_q, state_d;

  logic [ID_WIDTH-1:0]  ptr_q, ptr_d;
  logic [ID_WIDTH-1:0]  id_q;
  logic [3:0]           a_q, b_q;
  logic [2:0]           res_q, res_d;
  logic [CNT_WIDTH-1:0] cnt_q;

  logic [NUM_REQ-1:0]   grant;
  logic [ID_WIDTH-1:0]  win_idx;
  logic                 win_vld;
  logic                 arb_en;
  logic                 cmp_en;
  logic                 accept;
  logic                 done;
  logic [3:0]           a_sel, b_sel;

  wire cmp_gt, cmp_eq, cmp_lt;

  round_robin_arbiter #(
    .NUM_REQ  (NUM_REQ),
    .ID_WIDTH (ID_WIDTH)
  ) u_arb (
    .req_i    (Req_Valid_In),
    .ptr_i    (ptr_q),
    .enable_i (arb_en),
    .grant_o  (grant),
    .idx_o    (win_idx),
    .valid_o  (win_vld)
  );

  Comparator_4_Bit u_cmp (
    .A_In       (a_q),
    .B_In       (b_q),
    .Enable_In  (cmp_en),
    .A_gt_B_Out (cmp_gt),
    .A_eq_B_Out (cmp_eq),
    .A_lt_B_Out (cmp_lt)
  );

  assign accept = (state_q == IDLE) && win_vld;
  assign done   = (state_q == RESPOND) && Rsp_Ready_In;
  assign a_sel  = Req_Data_A_In[{win_idx, 2'b00} +: 4];
  assign b_sel  = Req_Data_B_In[{win_idx, 2'b00} +: 4];

  // pointer moves one past the winner, wrapping at NUM_REQ
  always_comb begin
    ptr_d = win_idx + ID_WIDTH'(1);
    if (win_idx == ID_WIDTH'(NUM_REQ - 1)) ptr_d = '0;
  end

  // fold comparator flags into a legal one-hot code
  always_comb begin
    res_d = RES_LT;
    if (cmp_gt) res_d = RES_GT;
    else if (cmp_eq) res_d = RES_EQ;
  end

  // state register
  always_ff @(posedge Clk_In or negedge Reset_n_In) begin
    if (!Reset_n_In) state_q <= IDLE;
    else state_q <= state_d;
  end

  // next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (win_vld) state_d = COMPARE;
      COMPARE: state_d = RESPOND;
      RESPOND: if (Rsp_Ready_In) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // outputs decoded from state; grants masked while in reset
  always_comb begin
    arb_en         = (state_q == IDLE) && Reset_n_In;
    cmp_en         = (state_q == COMPARE);
    Req_Ready_Out  = grant;
    Rsp_Valid_Out  = (state_q == RESPOND);
    Busy_Out       = (state_q != IDLE);
    Rsp_Id_Out     = id_q;
    Rsp_Result_Out = res_q;
    Done_Count_Out = cnt_q;
  end

  // operand, id, pointer, result and completion registers
  always_ff @(posedge Clk_In or negedge Reset_n_In) begin
    if (!Reset_n_In) begin
      ptr_q <= '0;
      id_q  <= '0;
      a_q   <= '0;
      b_q   <= '0;
      res_q <= '0;
      cnt_q <= '0;
    end else begin
      if (accept) begin
        a_q   <= a_sel;
        b_q   <= b_sel;
        id_q  <= win_idx;
        ptr_q <= ptr_d;
      end
      if (cmp_en) res_q <= res_d;
      if (done) cnt_q <= cnt_q + CNT_WIDTH'(1);
    end
  end

endmodule

// File: tb/tb_comparator_rr_scheduler.sv
// Directed + random bench for the shared
// comparator scheduler, model-checked.
module tb_comparator_rr_scheduler;

  localparam int N = 4;

  logic          Clk_In = 1'b0;
  logic          Reset_n_In;
  logic [N-1:0]  Req_Valid_In;
  logic [4*N-1:0] Req_Data_A_In;
  logic [4*N-1:0] Req_Data_B_In;
  logic [N-1:0]  Req_Ready_Out;
  logic          Rsp_Valid_Out;
  logic          Rsp_Ready_In;
  logic [1:0]    Rsp_Id_Out;
  logic [2:0]    Rsp_Result_Out;
  logic          Busy_Out;
  logic [7:0]    Done_Count_Out;

  int vectors = 0;
  int miscompares = 0;
  int ptr_m = 0;
  int cnt_m = 0;

  comparator_rr_scheduler #(
    .NUM_REQ   (N),
    .ID_WIDTH  (2),
    .CNT_WIDTH (8)
  ) dut (
    .Clk_In         (Clk_In),
    .Reset_n_In     (Reset_n_In),
    .Req_Valid_In   (Req_Valid_In),
    .Req_Data_A_In  (Req_Data_A_In),
    .Req_Data_B_In  (Req_Data_B_In),
    .Req_Ready_Out  (Req_Ready_Out),
    .Rsp_Valid_Out  (Rsp_Valid_Out),
    .Rsp_Ready_In   (Rsp_Ready_In),
    .Rsp_Id_Out     (Rsp_Id_Out),
    .Rsp_Result_Out (Rsp_Result_Out),
    .Busy_Out       (Busy_Out),
    .Done_Count_Out (Done_Count_Out)
  );

  always #5 Clk_In = ~Clk_In;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      $error("%s differs", tag);
    end
  endtask

  function automatic logic [2:0] golden(input int a, input int b);
    if (a > b) return 3'b100;
    if (a == b) return 3'b010;
    return 3'b001;
  endfunction

  // first valid requester at or after the model pointer
  function automatic int winner();
    for (int k = 0; k < N; k++) begin
      if (Req_Valid_In[(ptr_m + k) % N]) return (ptr_m + k) % N;
    end
    return -1;
  endfunction

  task automatic do_reset();
    Reset_n_In   = 1'b0;
    Req_Valid_In = '0;
    Rsp_Ready_In = 1'b0;
    repeat (2) @(posedge Clk_In);
    #1;
    Reset_n_In = 1'b1;
    ptr_m = 0;
    cnt_m = 0;
  endtask

  task automatic set_req(input int i, input int a, input int b);
    Req_Data_A_In[4*i +: 4] = a[3:0];
    Req_Data_B_In[4*i +: 4] = b[3:0];
  endtask

  // one full transaction; entered just after a clock edge in IDLE
  task automatic txn(input int hold, input bit drop);
    int w;
    logic [2:0] er;
    @(negedge Clk_In);
    w = winner();
    chk("grant", 32'(Req_Ready_Out), (w < 0) ? 0 : (1 << w));
    if (w < 0) begin
      @(posedge Clk_In);
      #1;
      return;
    end
    er = golden(int'(Req_Data_A_In[4*w +: 4]),
                int'(Req_Data_B_In[4*w +: 4]));
    ptr_m = (w + 1) % N;
    @(posedge Clk_In);
    #1;
    if (drop) Req_Valid_In[w] = 1'b0;
    chk("busy_cmp", 32'(Busy_Out), 1);
    chk("ready_cmp", 32'(Req_Ready_Out), 0);
    chk("valid_cmp", 32'(Rsp_Valid_Out), 0);
    Rsp_Ready_In = (hold == 0);
    @(posedge Clk_In);
    #1;
    for (int h = 0; h <= hold; h++) begin
      chk("rsp_valid", 32'(Rsp_Valid_Out), 1);
      chk("rsp_id", 32'(Rsp_Id_Out), w);
      chk("rsp_result", 32'(Rsp_Result_Out), 32'(er));
      chk("ready_rsp", 32'(Req_Ready_Out), 0);
      chk("cnt_hold", 32'(Done_Count_Out), cnt_m);
      if (h == hold) Rsp_Ready_In = 1'b1;
      @(posedge Clk_In);
      #1;
    end
    cnt_m = (cnt_m + 1) % 256;
    Rsp_Ready_In = 1'b0;
    chk("cnt_done", 32'(Done_Count_Out), cnt_m);
    chk("idle_valid", 32'(Rsp_Valid_Out), 0);
    chk("idle_busy", 32'(Busy_Out), 0);
  endtask

  initial begin
    Reset_n_In    = 1'b0;
    Req_Valid_In  = '0;
    Req_Data_A_In = '0;
    Req_Data_B_In = '0;
    Rsp_Ready_In  = 1'b0;
    #1;
    chk("rst_ready", 32'(Req_Ready_Out), 0);
    chk("rst_valid", 32'(Rsp_Valid_Out), 0);
    chk("rst_id", 32'(Rsp_Id_Out), 0);
    chk("rst_result", 32'(Rsp_Result_Out), 0);
    chk("rst_busy", 32'(Busy_Out), 0);
    chk("rst_cnt", 32'(Done_Count_Out), 0);
    do_reset();

    // nothing valid: stay idle
    @(negedge Clk_In);
    chk("nv_ready", 32'(Req_Ready_Out), 0);
    @(posedge Clk_In);
    #1;
    chk("nv_busy", 32'(Busy_Out), 0);

    // single request, A>B
    set_req(0, 1, 0);
    Req_Valid_In = 4'b0001;
    txn(0, 1);

    // requester 2 equal, then less-than
    set_req(2, 15, 15);
    Req_Valid_In = 4'b0100;
    txn(0, 1);
    set_req(2, 0, 1);
    Req_Valid_In = 4'b0100;
    txn(0, 1);

    // all requesters continuously valid from pointer 0
    do_reset();
    for (int i = 0; i < N; i++)
      set_req(i, $urandom_range(0, 15), $urandom_range(0, 15));
    Req_Valid_In = 4'b1111;
    for (int t = 0; t < 6; t++) txn(0, 0);

    // long backpressure with others waiting
    txn(10, 0);

    // reset in the middle of COMPARE
    Req_Valid_In = 4'b0010;
    @(negedge Clk_In);
    chk("mid_grant", 32'(Req_Ready_Out), 32'(1 << winner()));
    @(posedge Clk_In);
    #1;
    chk("mid_busy", 32'(Busy_Out), 1);
    Req_Valid_In = 4'b1010;
    Reset_n_In = 1'b0;
    #1;
    chk("mr_busy", 32'(Busy_Out), 0);
    chk("mr_valid", 32'(Rsp_Valid_Out), 0);
    chk("mr_ready", 32'(Req_Ready_Out), 0);
    chk("mr_id", 32'(Rsp_Id_Out), 0);
    chk("mr_result", 32'(Rsp_Result_Out), 0);
    chk("mr_cnt", 32'(Done_Count_Out), 0);
    ptr_m = 0;
    cnt_m = 0;
    @(posedge Clk_In);
    #1;
    chk("mr_hold", 32'(Rsp_Valid_Out), 0);
    Reset_n_In = 1'b1;
    set_req(1, 7, 3);
    set_req(3, 2, 9);
    txn(0, 1);
    txn(0, 1);

    // 256 random transactions from a fresh reset: counter wraps to 0
    do_reset();
    for (int t = 0; t < 256; t++) begin
      for (int i = 0; i < N; i++)
        set_req(i, $urandom_range(0, 15), $urandom_range(0, 15));
      Req_Valid_In = 4'($urandom_range(1, 15));
      Rsp_Ready_In = 1'($urandom_range(0, 1));
      txn($urandom_range(0, 3), 1'($urandom_range(0, 1)));
    end
    chk("cnt_wrap", 32'(Done_Count_Out), 0);

    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: observed running expected finished");
    $fatal(1, "timeout");
  end

endmodule
